// File: rtl/special_resolve_stage.sv
// Two-stage special-case resolver for a HUB floating-point adder: infinities, zeros and
// the +1/-1 cancellation are resolved here so the normal adder path can be skipped.
module special_resolve_stage #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [E+M:0]                  X,
  input  logic [E+M:0]                  Y,
  input  logic [$clog2(special_case):0] X_special_case,
  input  logic [$clog2(special_case):0] Y_special_case,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_bypass,
  output logic                          out_invalid,
  output logic [E+M:0]                  out_result,
  output logic [E+M:0]                  out_X,
  output logic [E+M:0]                  out_Y,
  output logic [15:0]                   bypass_count
);

  localparam int C = $clog2(special_case) + 1;
  localparam int W = E + M + 1;

  localparam logic [W-1:0] PINF  = {1'b0, {(E+M){1'b1}}};
  localparam logic [W-1:0] NINF  = {1'b1, {(E+M){1'b1}}};
  localparam logic [W-1:0] PZERO = '0;
  localparam logic [W-1:0] NZERO = {1'b1, {(E+M){1'b0}}};

  // Codes outside the defined set carry no special meaning.
  function automatic logic [2:0] norm_code(input logic [C-1:0] c);
    return (int'(c) < 7) ? 3'(c) : 3'd0;
  endfunction

  // Returns {bypass, invalid, result}.
  function automatic logic [W+1:0] resolve(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] xc, input logic [2:0] yc);
    logic         xi, yi, xz, yz, b, v;
    logic [W-1:0] r;
    xi = (xc == 3'd1) || (xc == 3'd2);
    yi = (yc == 3'd1) || (yc == 3'd2);
    xz = (xc == 3'd3) || (xc == 3'd4);
    yz = (yc == 3'd3) || (yc == 3'd4);
    b  = 1'b1;
    v  = 1'b0;
    r  = PZERO;
    if (xi && !yi)      r = (xc == 3'd1) ? PINF : NINF;
    else if (!xi && yi) r = (yc == 3'd1) ? PINF : NINF;
    else if (xi && yi) begin
      if (xc == yc) r = (xc == 3'd1) ? PINF : NINF;
      else begin
        r = PINF;
        v = 1'b1;
      end
    end
    else if (xz)        r = yz ? (((xc == 3'd4) && (yc == 3'd4)) ? NZERO : PZERO) : y;
    else if (yz)        r = x;
    else if (((xc == 3'd5) && (yc == 3'd6)) || ((xc == 3'd6) && (yc == 3'd5))) r = PZERO;
    else                b = 1'b0;
    return {b, v, r};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic           w_advance;
  logic [W+1:0]   w_res;

  logic           r_vld_p1;
  logic [W-1:0]   r_x_p1, r_y_p1;
  logic [C-1:0]   r_xc_p1, r_yc_p1;

  logic           r_vld_p2, r_byp_p2, r_inv_p2;
  logic [W-1:0]   r_res_p2, r_x_p2, r_y_p2;
  logic [15:0]    r_bcnt;

  assign w_advance = !r_vld_p2 || out_ready;
  assign w_res     = resolve(r_x_p1, r_y_p1, norm_code(r_xc_p1), norm_code(r_yc_p1));

  // ---- S1: capture operands and class codes ----
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_x_p1  <= X;
      r_y_p1  <= Y;
      r_xc_p1 <= X_special_case;
      r_yc_p1 <= Y_special_case;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         r_vld_p1 <= 1'b0;
    else if (w_advance) r_vld_p1 <= in_valid;
  end

  // ---- S2: resolved result and forwarded operands ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_byp_p2 <= 1'b0;
      r_inv_p2 <= 1'b0;
      r_res_p2 <= '0;
      r_x_p2   <= '0;
      r_y_p2   <= '0;
    end else if (w_advance) begin
      r_vld_p2 <= r_vld_p1;
      r_byp_p2 <= r_vld_p1 & w_res[W+1];
      r_inv_p2 <= r_vld_p1 & w_res[W];
      r_res_p2 <= (r_vld_p1 && w_res[W+1]) ? w_res[W-1:0] : '0;
      r_x_p2   <= r_x_p1;
      r_y_p2   <= r_y_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                              r_bcnt <= '0;
    else if (r_vld_p2 && out_ready && r_byp_p2) r_bcnt <= sat_inc(r_bcnt);
  end

  assign in_ready     = w_advance;
  assign out_valid    = r_vld_p2;
  assign out_bypass   = r_byp_p2;
  assign out_invalid  = r_inv_p2;
  assign out_result   = r_res_p2;
  assign out_X        = r_x_p2;
  assign out_Y        = r_y_p2;
  assign bypass_count = r_bcnt;

endmodule

// File: tb/tb_special_resolve_stage.sv
// Scoreboard bench for special_resolve_stage (M=23, E=8): a driver pushes model results,
// a monitor pops and compares every delivered result, plus stall, reset and saturation cases.
module tb_special_resolve_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] X, Y, out_result, out_X, out_Y;
  logic [3:0]  X_special_case, Y_special_case;
  logic        out_bypass, out_invalid;
  logic [15:0] bypass_count;

  special_resolve_stage #(.M(23), .E(8), .special_case(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .X_special_case(X_special_case), .Y_special_case(Y_special_case),
    .out_valid(out_valid), .out_ready(out_ready), .out_bypass(out_bypass),
    .out_invalid(out_invalid), .out_result(out_result), .out_X(out_X), .out_Y(out_Y),
    .bypass_count(bypass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, res;
    logic        byp, inv, lat;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        me;
  int          nchk = 0, npass = 0, cyc = 0;
  logic [15:0] mcnt = 0;
  logic        rdy_rand = 0, lat_chk = 1, held_v = 0;
  logic [97:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Reference behaviour: classify each operand, then apply the resolution rules.
  function automatic exp_t model(input logic [31:0] x, y, input logic [3:0] xc, yc);
    exp_t e;
    int   cx, cy;
    bit   xinf, yinf, xneg, yneg, xz, yz;
    cx = (xc > 6) ? 0 : int'(xc);
    cy = (yc > 6) ? 0 : int'(yc);
    xinf = (cx == 1 || cx == 2); xneg = (cx == 2);
    yinf = (cy == 1 || cy == 2); yneg = (cy == 2);
    xz = (cx == 3 || cx == 4);
    yz = (cy == 3 || cy == 4);
    e.x = x; e.y = y; e.byp = 1; e.inv = 0; e.res = 32'h0; e.lat = 0; e.cyc = 0;
    if (xinf || yinf) begin
      if (xinf && yinf && xneg != yneg) begin
        e.res = 32'h7FFFFFFF; e.inv = 1;
      end else begin
        e.res = (xinf ? xneg : yneg) ? 32'hFFFFFFFF : 32'h7FFFFFFF;
      end
    end else if (xz && yz) e.res = (cx == 4 && cy == 4) ? 32'h80000000 : 32'h00000000;
    else if (xz) e.res = y;
    else if (yz) e.res = x;
    else if ((cx == 5 && cy == 6) || (cx == 6 && cy == 5)) e.res = 32'h0;
    else e.byp = 0;
    return e;
  endfunction

  // Called at a negedge; returns at a later negedge once the pair has been accepted.
  task automatic send(input logic [31:0] x, y, input logic [3:0] xc, yc);
    exp_t e;
    bit   done;
    done = 0;
    in_valid = 1; X = x; Y = y; X_special_case = xc; Y_special_case = yc;
    for (int t = 0; t < 300 && !done; t++) begin
      #3;
      if (in_ready) begin
        e = model(x, y, xc, yc);
        e.lat = lat_chk;
        e.cyc = cyc;
        exp_q.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);

  // Monitor: samples just before the next rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst_n) held_v = 0;
    else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (held_v) check("stall_stable", {out_valid, out_bypass, out_invalid, out_result, out_X, out_Y},
                        {1'b1, held});
      held_v = out_valid && !out_ready;
      held   = {out_bypass, out_invalid, out_result, out_X, out_Y};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          me = exp_q.pop_front();
          check("bypass", out_bypass, me.byp);
          check("invalid", out_invalid, me.inv);
          check("result", out_result, me.res);
          check("fwd_x", out_X, me.x);
          check("fwd_y", out_Y, me.y);
          check("bcount", bypass_count, mcnt);
          if (me.lat) check("latency", cyc - me.cyc, 2);
          if (me.byp && mcnt != 16'hFFFF) mcnt = mcnt + 1;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; X = 0; Y = 0;
    X_special_case = 0; Y_special_case = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcount", bypass_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_fwd", {out_X, out_Y, out_bypass, out_invalid}, 0);
    rst_n = 1;
    @(negedge clk);

    // Directed classes
    send(32'h7FFFFFFF, 32'h3F800000, 4'd1, 4'd0);
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd2);
    send(32'h80000000, 32'h80000000, 4'd4, 4'd4);
    send(32'h00000000, 32'h80000000, 4'd3, 4'd4);
    send(32'h40000000, 32'hC0000000, 4'd5, 4'd6);
    send(32'h3F800000, 32'h40400000, 4'd0, 4'd0);
    send(32'h12345678, 32'hFFFFFFFF, 4'd9, 4'd2);
    send(32'h12345678, 32'h00000000, 4'd15, 4'd3);
    drain();
    check("bcount_directed", bypass_count, 7);

    // Back-to-back with a 3-cycle downstream stall
    lat_chk = 0;
    fork
      begin
        send(32'h11111111, 32'h22222222, 4'd0, 4'd0);
        send(32'h33333333, 32'hFFFFFFFF, 4'd0, 4'd2);
        send(32'h44444444, 32'h00000000, 4'd0, 4'd3);
        send(32'h55555555, 32'h66666666, 4'd6, 4'd5);
      end
      begin
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        check("stall_seen", out_valid, 1);
        out_ready = 0;
        #2 check("stall_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    drain();

    // Randomized traffic with random backpressure
    rdy_rand = 1;
    for (int i = 0; i < 400; i++) begin
      send($urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    rdy_rand = 0;
    out_ready = 1;
    @(negedge clk);

    // Reset with both stages full
    out_ready = 0;
    send(32'hAAAA0000, 32'h0, 4'd1, 4'd0);
    send(32'hBBBB0000, 32'h0, 4'd0, 4'd3);
    #1;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst_n = 0;
    exp_q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check("postrst_out_valid", out_valid, 0);
    check("postrst_bcount", bypass_count, 0);
    check("postrst_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (4) @(negedge clk);

    // Saturation of the bypass counter
    lat_chk = 1;
    for (int i = 0; i < 65540; i++) send($urandom, $urandom, 4'd1, 4'($urandom_range(0, 15)));
    drain();
    check("bcount_saturated", bypass_count, 16'hFFFF);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
